stage_ex_md: RTL and testbench

STAGE_EX_MD -- requirements
Module: stage_ex_md

---
 rtl/ex_pkg.sv | 41 ++++
 rtl/ex_muldiv.sv | 113 +++++++++++
 rtl/stage_ex_md.sv | 127 ++++++++++++
 tb/tb_stage_ex_md.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU opcodes, forward/destination selects and op classification.
package ex_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_NOR   = 5'd5,
        OP_SLT   = 5'd6,
        OP_SLTU  = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLLV  = 5'd11,
        OP_SRLV  = 5'd12,
        OP_SRAV  = 5'd13,
        OP_LUI   = 5'd14,
        OP_MFHI  = 5'd15,
        OP_MFLO  = 5'd16,
        OP_MULT  = 5'd17,
        OP_MULTU = 5'd18,
        OP_DIV   = 5'd19,
        OP_DIVU  = 5'd20
    } alu_op_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;
    localparam logic [4:0] RA_IDX = 5'd31;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide: one shift-add or restoring-divide step per cycle on magnitudes,
// sign fix-up and divide special cases applied as HI/LO are written on the last step.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    logic              w_div, w_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
    logic [2*XLEN-1:0] w_next, w_prod;
    logic [XLEN-1:0]   w_q, w_r, w_hi_fin, w_lo_fin;

    logic              r_busy, r_done, r_div, r_neg_q, r_neg_r, r_div0;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_a, r_b_mag, r_hi, r_lo;

    assign w_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_neg  = w_signed & a[XLEN-1];
    assign w_b_neg  = w_signed & b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // r_p holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        w_sum    = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b_mag} : '0);
        w_rem_sh = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_b_mag};
        if (!r_div)
            w_next = {w_sum, r_p[XLEN-1:1]};
        else if (!w_diff[XLEN])
            w_next = {w_diff[XLEN-1:0], r_p[XLEN-2:0], 1'b1};
        else
            w_next = {w_rem_sh[XLEN-1:0], r_p[XLEN-2:0], 1'b0};
        w_prod = r_neg_q ? -w_next : w_next;
        w_q    = r_neg_q ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
        w_r    = r_neg_r ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];
        if (!r_div) begin
            w_hi_fin = w_prod[2*XLEN-1:XLEN];
            w_lo_fin = w_prod[XLEN-1:0];
        end else if (r_div0) begin
            w_hi_fin = r_a;
            w_lo_fin = '1;
        end else begin
            w_hi_fin = w_r;
            w_lo_fin = w_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end else if (r_busy) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_hi   <= w_hi_fin;
                    r_lo   <= w_lo_fin;
                end
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        if (start && !r_busy) begin
            r_p     <= {{XLEN{1'b0}}, w_a_mag};
            r_a     <= a;
            r_b_mag <= w_b_mag;
            r_div   <= w_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= (b == '0);
        end else if (r_busy) begin
            r_p <= w_next;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: rtl/stage_ex_md.sv
// EX stage with operand forwarding, single-cycle ALU and EX/MEM latch.
// Define EX_MULDIV_EN to build the multi-cycle multiply/divide unit with HI/LO.
module stage_ex_md
    import ex_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_flush,
    input  logic [4:0]               alu_op,
    input  logic                     alu_src,
    input  logic [1:0]               fwd_a,
    input  logic [1:0]               fwd_b,
    input  logic [XLEN-1:0]          data_rs,
    input  logic [XLEN-1:0]          data_rt,
    input  logic [XLEN-1:0]          imm,
    input  logic [XLEN-1:0]          wb_data,
    input  logic [$clog2(XLEN)-1:0]  sa,
    input  logic [4:0]               rt,
    input  logic [4:0]               rd,
    input  logic [1:0]               reg_dst,
    input  logic [CTRL_W-1:0]        ctrl_in,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_alu,
    output logic [XLEN-1:0]          out_data_rt,
    output logic [4:0]               out_wreg,
    output logic [CTRL_W-1:0]        ctrl_out,
    output logic                     stall
);

    localparam int SH_W = $clog2(XLEN);

    logic [XLEN-1:0] w_op_a, w_fwd_b, w_op_b, w_result, w_hi, w_lo;
    logic [4:0]      w_wreg;
    logic            w_is_md, w_stall;

    assign w_is_md = is_md_op(alu_op);
    assign w_op_b  = alu_src ? imm : w_fwd_b;

    always_comb begin
        case (fwd_a)
            FWD_MEM: w_op_a = out_alu;
            FWD_WB:  w_op_a = wb_data;
            default: w_op_a = data_rs;
        endcase
        case (fwd_b)
            FWD_MEM: w_fwd_b = out_alu;
            FWD_WB:  w_fwd_b = wb_data;
            default: w_fwd_b = data_rt;
        endcase
        case (reg_dst)
            DST_RD:  w_wreg = rd;
            DST_RA:  w_wreg = RA_IDX;
            default: w_wreg = rt;
        endcase
    end

    always_comb begin
        case (alu_op)
            OP_ADD:  w_result = w_op_a + w_op_b;
            OP_SUB:  w_result = w_op_a - w_op_b;
            OP_AND:  w_result = w_op_a & w_op_b;
            OP_OR:   w_result = w_op_a | w_op_b;
            OP_XOR:  w_result = w_op_a ^ w_op_b;
            OP_NOR:  w_result = ~(w_op_a | w_op_b);
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            OP_SLL:  w_result = w_op_b << sa;
            OP_SRL:  w_result = w_op_b >> sa;
            OP_SRA:  w_result = $unsigned($signed(w_op_b) >>> sa);
            OP_SLLV: w_result = w_op_b << w_op_a[SH_W-1:0];
            OP_SRLV: w_result = w_op_b >> w_op_a[SH_W-1:0];
            OP_SRAV: w_result = $unsigned($signed(w_op_b) >>> w_op_a[SH_W-1:0]);
            OP_LUI:  w_result = w_op_b << (XLEN / 2);
            OP_MFHI: w_result = w_hi;
            OP_MFLO: w_result = w_lo;
            default: w_result = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic w_md_start, w_md_busy, w_md_done;

    // The held MD op is still in EX on the done cycle; done blocks a second start.
    assign w_md_start = ~reset & in_valid & w_is_md & ~w_md_busy & ~w_md_done;
    assign w_stall    = w_md_start | w_md_busy;

    ex_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (w_md_start),
        .op    (alu_op),
        .a     (w_op_a),
        .b     (w_fwd_b),
        .busy  (w_md_busy),
        .done  (w_md_done),
        .hi    (w_hi),
        .lo    (w_lo)
    );
`else
    assign w_stall = 1'b0;
    assign w_hi    = '0;
    assign w_lo    = '0;
`endif

    assign stall = w_stall;

    always_ff @(posedge clk) begin
        if (reset || in_flush || w_stall || w_is_md) begin
            out_valid   <= 1'b0;
            out_alu     <= '0;
            out_data_rt <= '0;
            out_wreg    <= '0;
            ctrl_out    <= '0;
        end else begin
            out_valid   <= in_valid;
            out_alu     <= w_result;
            out_data_rt <= w_fwd_b;
            out_wreg    <= w_wreg;
            ctrl_out    <= ctrl_in;
        end
    end

endmodule

// File: tb/tb_stage_ex_md.sv
// Randomized bench for stage_ex_md against an arithmetic reference model of the EX stage.
// Multiply/divide scenarios follow whether EX_MULDIV_EN is defined for the build.
module tb_stage_ex_md;
    import ex_pkg::*;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    logic              clk, reset, in_valid, in_flush, alu_src;
    logic [4:0]        alu_op, rt, rd, sa;
    logic [1:0]        fwd_a, fwd_b, reg_dst;
    logic [XLEN-1:0]   data_rs, data_rt, imm, wb_data;
    logic [CTRL_W-1:0] ctrl_in, ctrl_out;
    logic              out_valid, stall;
    logic [XLEN-1:0]   out_alu, out_data_rt;
    logic [4:0]        out_wreg;

    int total, bad;
    logic [XLEN-1:0] m_hi, m_lo, m_alu;

    stage_ex_md #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flush(in_flush),
        .alu_op(alu_op), .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .data_rs(data_rs), .data_rt(data_rt), .imm(imm), .wb_data(wb_data),
        .sa(sa), .rt(rt), .rd(rd), .reg_dst(reg_dst), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_alu(out_alu), .out_data_rt(out_data_rt),
        .out_wreg(out_wreg), .ctrl_out(ctrl_out), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_flush = 0; alu_op = OP_ADD; alu_src = 0;
        fwd_a = 2'b00; fwd_b = 2'b00; data_rs = '0; data_rt = '0; imm = '0;
        wb_data = '0; sa = '0; rt = '0; rd = '0; reg_dst = 2'b00; ctrl_in = '0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] mem_v, input logic [31:0] wb_v);
        if (sel == 2'b01) return mem_v;
        if (sel == 2'b10) return wb_v;
        return reg_v;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] s);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return b << s;
            OP_SRL:  return b >> s;
            OP_SRA:  return int'(b) >>> s;
            OP_SLLV: return b << a[4:0];
            OP_SRLV: return b >> a[4:0];
            OP_SRAV: return int'(b) >>> a[4:0];
            OP_LUI:  return {b[15:0], 16'h0000};
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        longint unsigned pu;
        case (op)
            OP_MULT: begin
                p = longint'(int'(a)) * longint'(int'(b));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            OP_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32]; m_lo = pu[31:0];
            end
            OP_DIV: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                else begin m_lo = int'(a) / int'(b); m_hi = int'(a) % int'(b); end
            end
            default: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
        endcase
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        total++;
        if ({out_valid, out_alu, out_data_rt, out_wreg, ctrl_out} !== '0) begin
            bad++;
            $display("FAIL reset_latch: got v=%0b alu=%h rt=%h w=%0d c=%h, want all 0",
                     out_valid, out_alu, out_data_rt, out_wreg, ctrl_out);
        end
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        reset = 0;
        m_hi = 0; m_lo = 0; m_alu = 0;
    endtask

    task automatic test_directed();
        idle_inputs();
        in_valid = 1; alu_op = OP_ADD; data_rs = 32'd5; imm = 32'hFFFF_FFFF; alu_src = 1;
        rt = 5'd3; rd = 5'd7; reg_dst = DST_RD; ctrl_in = 8'hA5;
        tick();
        total++;
        if (out_alu !== 32'd4 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL add_imm: got alu=%h v=%b want alu=00000004 v=1", out_alu, out_valid);
        end
        total++;
        if (out_wreg !== 5'd7 || ctrl_out !== 8'hA5) begin
            bad++;
            $display("FAIL add_wreg_ctrl: got w=%0d c=%h want w=7 c=a5", out_wreg, ctrl_out);
        end
        alu_src = 0; data_rs = 32'h10; data_rt = 32'h0; reg_dst = DST_RA;
        tick();
        total++;
        if (out_alu !== 32'h10 || out_wreg !== 5'd31) begin
            bad++;
            $display("FAIL add_ra: got alu=%h w=%0d want alu=00000010 w=31", out_alu, out_wreg);
        end
        alu_op = OP_SUB; fwd_a = 2'b01; fwd_b = 2'b10; wb_data = 32'd3;
        data_rs = 32'h999; data_rt = 32'h777;
        tick();
        total++;
        if (out_alu !== 32'h0D || out_data_rt !== 32'd3) begin
            bad++;
            $display("FAIL sub_fwd: got alu=%h rt=%h want alu=0000000d rt=00000003",
                     out_alu, out_data_rt);
        end
        m_alu = out_alu === 32'h0D ? 32'h0D : 32'h0D;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [4:0] ops [17] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
                                 OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV,
                                 OP_SRAV, OP_LUI, OP_MFHI, OP_MFLO};
        logic [31:0] a, bf, b, e_alu, e_rt;
        logic [4:0]  e_w;
        logic        e_v;
        logic [7:0]  e_c;
        int stall_hits = 0;
        for (int i = 0; i < 240; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_flush = (i == 0) || ($urandom_range(0, 7) == 0);
            alu_op   = ops[$urandom_range(0, 16)];
            alu_src  = 1'($urandom_range(0, 1));
            fwd_a    = 2'($urandom_range(0, 3));
            fwd_b    = 2'($urandom_range(0, 3));
            data_rs  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            data_rt  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            imm      = $urandom;
            wb_data  = $urandom;
            sa       = 5'($urandom);
            rt       = 5'($urandom);
            rd       = 5'($urandom);
            reg_dst  = 2'($urandom);
            ctrl_in  = 8'($urandom);
            if (in_flush) begin
                e_v = 0; e_alu = 0; e_rt = 0; e_w = 0; e_c = 0;
            end else begin
                a  = pick(fwd_a, data_rs, m_alu, wb_data);
                bf = pick(fwd_b, data_rt, m_alu, wb_data);
                b  = alu_src ? imm : bf;
                e_v = in_valid; e_alu = alu_ref(alu_op, a, b, sa); e_rt = bf; e_c = ctrl_in;
                e_w = (reg_dst == 2'b01) ? rd : (reg_dst == 2'b10) ? 5'd31 : rt;
            end
            #1;
            if (stall !== 1'b0) stall_hits++;
            tick();
            total++;
            if (out_valid !== e_v || out_alu !== e_alu || out_data_rt !== e_rt ||
                out_wreg !== e_w || ctrl_out !== e_c) begin
                bad++;
                $display("FAIL random[%0d] op=%0d: got v=%b alu=%h rt=%h w=%0d c=%h want v=%b alu=%h rt=%h w=%0d c=%h",
                         i, alu_op, out_valid, out_alu, out_data_rt, out_wreg, ctrl_out,
                         e_v, e_alu, e_rt, e_w, e_c);
            end
            m_alu = e_alu;
        end
        total++;
        if (stall_hits != 0) begin
            bad++;
            $display("FAIL random_stall: got %0d stall cycles want 0", stall_hits);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        in_valid = 1; alu_op = OP_ADD; data_rs = 32'd9; data_rt = 32'd4; ctrl_in = 8'h3C;
        tick();
        in_flush = 1;
        tick();
        total++;
        if (out_valid !== 1'b0 || ctrl_out !== '0 || out_alu !== '0 || out_data_rt !== '0) begin
            bad++;
            $display("FAIL flush: got v=%b c=%h alu=%h rt=%h want all 0",
                     out_valid, ctrl_out, out_alu, out_data_rt);
        end
        m_alu = 0;
        idle_inputs();
    endtask

    task automatic read_hilo(input string name);
        idle_inputs();
        in_valid = 1; alu_op = OP_MFHI; reg_dst = 2'($urandom);
        tick();
        total++;
        if (out_alu !== m_hi || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_hi: got %h v=%b want %h v=1", name, out_alu, out_valid, m_hi);
        end
        alu_op = OP_MFLO;
        tick();
        total++;
        if (out_alu !== m_lo || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_lo: got %h v=%b want %h v=1", name, out_alu, out_valid, m_lo);
        end
        idle_inputs();
    endtask

`ifdef EX_MULDIV_EN
    task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic flush_during);
        int n = 0;
        int bubble_bad = 0;
        logic fin = 0;
        idle_inputs();
        in_valid = 1; alu_op = op; data_rs = a; data_rt = b; in_flush = flush_during;
        ctrl_in = 8'($urandom); rd = 5'($urandom);
        for (int i = 0; i < 100 && !fin; i++) begin
            #1;
            if (stall === 1'b1) n++;
            else fin = 1;
            tick();
            if (out_valid !== 1'b0 || ctrl_out !== '0 || out_alu !== '0) bubble_bad++;
        end
        total++;
        if (n != XLEN + 1) begin
            bad++;
            $display("FAIL %s_stall_len: got %0d cycles want %0d", name, n, XLEN + 1);
        end
        total++;
        if (bubble_bad != 0) begin
            bad++;
            $display("FAIL %s_bubbles: got %0d non-bubble cycles want 0", name, bubble_bad);
        end
        md_ref(op, a, b);
        m_alu = 0;
        idle_inputs();
    endtask

    task automatic test_muldiv();
        logic [4:0] mops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        logic [31:0] ra, rb;
        run_md("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        read_hilo("mult");
        run_md("div0", OP_DIV, 32'd7, 32'd0, 1'b0);
        read_hilo("div0");
        run_md("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        read_hilo("divovf");
        run_md("divneg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        read_hilo("divneg");
        run_md("multu_flush", OP_MULTU, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1);
        run_md("divu_b2b", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0);
        read_hilo("b2b");
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_md("md_rand", mops[i % 4], ra, rb, 1'b0);
            read_hilo("md_rand");
        end
    endtask
`else
    task automatic test_muldiv();
        int hits = 0;
        int not_bubble = 0;
        idle_inputs();
        in_valid = 1; alu_op = OP_MULT; data_rs = 32'hFFFF_FFFF; data_rt = 32'd2;
        ctrl_in = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall !== 1'b0) hits++;
            tick();
            if (out_valid !== 1'b0 || ctrl_out !== '0) not_bubble++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL nomd_stall: got %0d stall cycles want 0", hits);
        end
        total++;
        if (not_bubble != 0) begin
            bad++;
            $display("FAIL nomd_bubble: got %0d non-bubble cycles want 0", not_bubble);
        end
        m_alu = 0;
        read_hilo("nomd");
    endtask
`endif

    task automatic test_reset_mid_md();
        idle_inputs();
        in_valid = 1; alu_op = OP_DIVU; data_rs = $urandom; data_rt = 32'd3;
        for (int i = 0; i < 10; i++) tick();
        reset = 1;
        tick();
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_md_stall: got %b want 0", stall);
        end
        total++;
        if ({out_valid, out_alu, out_data_rt, out_wreg, ctrl_out} !== '0) begin
            bad++;
            $display("FAIL reset_md_latch: got v=%b alu=%h rt=%h w=%0d c=%h want all 0",
                     out_valid, out_alu, out_data_rt, out_wreg, ctrl_out);
        end
        reset = 0;
        in_valid = 0;
        m_hi = 0; m_lo = 0; m_alu = 0;
        read_hilo("reset_md");
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_muldiv();
        test_reset_mid_md();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
